// File: rtl/sel_pipe_pkg.sv
// sel_pipe_pkg: shared types and helpers for the sel_pipe_mux block.
//   state_e     : skid-buffer occupancy (EMPTY / ONE / TWO)
//   DEF_WIDTH   : default data word width
//   DEF_NUM_IN  : default number of selectable input words
//   word_slice  : returns word <idx> of a packed bus of <width>-bit words
//   even_par    : XOR-reduce of a word
// word_slice works on a bus of up to MAX_BUS bits and words of up to
// MAX_WIDTH bits; instantiations must stay inside those limits.
package sel_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;
  localparam int MAX_WIDTH  = 256;
  localparam int MAX_BUS    = 8192;

  // Shift the wanted word down to bit 0, then mask off everything above it.
  function automatic logic [MAX_WIDTH-1:0] word_slice(
    input logic [MAX_BUS-1:0] bus,
    input int unsigned        idx,
    input int unsigned        width
  );
    logic [MAX_WIDTH-1:0] mask;
    if (width >= MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (MAX_WIDTH'(1'b1) << width) - MAX_WIDTH'(1'b1);
    end
    return MAX_WIDTH'(bus >> (idx * width)) & mask;
  endfunction

  function automatic logic even_par(input logic [MAX_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/sel_pipe_mux_if.sv
// sel_pipe_mux_if: handshake bundle of sel_pipe_mux.
//   upstream   : in_data, in_sel, in_valid -> ; <- in_ready ; flush
//   downstream : <- out_data, out_sel, out_valid, sel_err ; out_ready ->
//   out_par exists only when SEL_PIPE_MUX_PARITY_EN is defined.
// modport slave is the block itself; modport master is its environment.
interface sel_pipe_mux_if
  import sel_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
`ifdef SEL_PIPE_MUX_PARITY_EN
  logic                    out_par;
`endif

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
`ifdef SEL_PIPE_MUX_PARITY_EN
    output out_par,
`endif
    output in_ready, out_data, out_sel, out_valid, sel_err
  );

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
`ifdef SEL_PIPE_MUX_PARITY_EN
    input  out_par,
`endif
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/sel_pipe_mux_comb.sv
// sel_pipe_mux_comb: combinational N:1 word selector (generalised 2:1 mux).
//   in_data : NUM_IN packed words, word i at [i*WIDTH +: WIDTH]
//   in_sel  : index of the wanted word
//   word    : selected word, forced to zero when in_sel >= NUM_IN
//   err     : high when in_sel >= NUM_IN
module sel_pipe_mux_comb
  import sel_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);

  // Pick the indexed word; an index past the last word yields zero data.
  always_comb begin
    word = '0;
    err  = 1'b0;
    if (int'(in_sel) < NUM_IN) begin
      word = WIDTH'(word_slice(MAX_BUS'(in_data), 32'(in_sel), 32'(WIDTH)));
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: registered N:1 word selector with valid/ready handshake and
// a two-entry skid buffer (OREG drives the outputs, SREG catches the word
// accepted while the output is stalled).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : sel_pipe_mux_if.slave (in_* upstream side, out_* downstream
//              side, flush, one-cycle sel_err pulse)
// Optional: define SEL_PIPE_MUX_PARITY_EN to add out_par, the XOR-reduce of
// out_data, carried through OREG/SREG so it stays aligned with the data.
module sel_pipe_mux
  import sel_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN
) (
  input logic           clk,
  input logic           rst,
  sel_pipe_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  state_e             state_r, state_nxt_s;
  logic [WIDTH-1:0]   oreg_data_r, sreg_data_r, mux_word_s;
  logic [SEL_W-1:0]   oreg_sel_r, sreg_sel_r;
  logic               in_ready_r, out_valid_r, sel_err_r;
  logic               mux_err_s, accept_s, take_s;
  logic               load_o_s, load_s_s, shift_s;
`ifdef SEL_PIPE_MUX_PARITY_EN
  logic               oreg_par_r, sreg_par_r, mux_par_s;
  assign mux_par_s   = even_par(MAX_WIDTH'(mux_word_s));
  assign bus.out_par = oreg_par_r;
`endif

  sel_pipe_mux_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_comb (
    .in_data (bus.in_data),
    .in_sel  (bus.in_sel),
    .word    (mux_word_s),
    .err     (mux_err_s)
  );

  assign accept_s      = bus.in_valid && in_ready_r;
  assign take_s        = out_valid_r && bus.out_ready;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = oreg_data_r;
  assign bus.out_sel   = oreg_sel_r;
  assign bus.sel_err   = sel_err_r;

  // Next occupancy and register load strobes; flush overrides every move.
  always_comb begin
    state_nxt_s = state_r;
    load_o_s    = 1'b0;
    load_s_s    = 1'b0;
    shift_s     = 1'b0;
    if (bus.flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ONE;
            load_o_s    = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && !take_s) begin
            state_nxt_s = TWO;
            load_s_s    = 1'b1;
          end else if (!accept_s && take_s) begin
            state_nxt_s = EMPTY;
          end else if (accept_s && take_s) begin
            state_nxt_s = ONE;
            load_o_s    = 1'b1;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          if (take_s) begin
            state_nxt_s = ONE;
            shift_s     = 1'b1;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State, handshake flags and OREG/SREG contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sel_err_r   <= 1'b0;
      oreg_data_r <= '0;
      oreg_sel_r  <= '0;
      sreg_data_r <= '0;
      sreg_sel_r  <= '0;
`ifdef SEL_PIPE_MUX_PARITY_EN
      oreg_par_r  <= 1'b0;
      sreg_par_r  <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      // Handshake flags are decoded from the next state so they leave flops.
      in_ready_r  <= (state_nxt_s != TWO);
      out_valid_r <= (state_nxt_s != EMPTY);
      sel_err_r   <= accept_s && mux_err_s && !bus.flush;
      if (load_o_s) begin
        oreg_data_r <= mux_word_s;
        oreg_sel_r  <= bus.in_sel;
`ifdef SEL_PIPE_MUX_PARITY_EN
        oreg_par_r  <= mux_par_s;
`endif
      end else if (shift_s) begin
        oreg_data_r <= sreg_data_r;
        oreg_sel_r  <= sreg_sel_r;
`ifdef SEL_PIPE_MUX_PARITY_EN
        oreg_par_r  <= sreg_par_r;
`endif
      end
      if (load_s_s) begin
        sreg_data_r <= mux_word_s;
        sreg_sel_r  <= bus.in_sel;
`ifdef SEL_PIPE_MUX_PARITY_EN
        sreg_par_r  <= mux_par_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sel_pipe_mux.sv
// tb_sel_pipe_mux: drives a NUM_IN=4 and a NUM_IN=3 instance with identical
// stimulus; a queue-based transfer model predicts both, a vector table covers
// streaming, back-pressure and flush, and hand sequences cover async reset,
// out-of-range select and (with SEL_PIPE_MUX_PARITY_EN) parity.
module tb_sel_pipe_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sel_pipe_mux_if #(.WIDTH(32), .NUM_IN(4)) if4 ();
  sel_pipe_mux_if #(.WIDTH(32), .NUM_IN(3)) if3 ();

  sel_pipe_mux #(.WIDTH(32), .NUM_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  sel_pipe_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
  } mword_t;

  typedef struct packed {
    logic        iv;
    logic [1:0]  sel;
    logic        fl;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic [1:0]  os;
    logic        err;
  } vec_t;

  mword_t       q4[$];
  mword_t       q3[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] din;
  vec_t         tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic mword_t pick(input logic [127:0] d, input logic [1:0] s, input int n);
    mword_t w;
    w.sel  = s;
    w.data = (int'(s) < n) ? d[32*s +: 32] : 32'h0;
    return w;
  endfunction

  task automatic drive(input logic iv, input logic [1:0] s, input logic fl, input logic ordy);
    if4.in_data = din;          if3.in_data = din[95:0];
    if4.in_sel = s;             if3.in_sel = s;
    if4.in_valid = iv;          if3.in_valid = iv;
    if4.flush = fl;             if3.flush = fl;
    if4.out_ready = ordy;       if3.out_ready = ordy;
  endtask

  task automatic cmp_model(input string tag, input logic ov, input logic ir, input logic err,
                           input logic [31:0] od, input logic [1:0] os, input logic op,
                           input int size, input mword_t front, input logic exp_err);
    check({tag, "_valid"}, 64'(ov), 64'(size > 0));
    check({tag, "_in_ready"}, 64'(ir), 64'(size < 2));
    check({tag, "_sel_err"}, 64'(err), 64'(exp_err));
    if (size > 0) begin
      check({tag, "_data"}, 64'(od), 64'(front.data));
      check({tag, "_sel"}, 64'(os), 64'(front.sel));
`ifdef SEL_PIPE_MUX_PARITY_EN
      check({tag, "_par"}, 64'(op), 64'(^front.data));
`endif
    end
  endtask

  // One clock: apply inputs, advance the transfer model, compare #1 after the edge.
  task automatic step(input logic iv, input logic [1:0] s, input logic fl, input logic ordy);
    logic acc4, acc3, tk4, tk3, e4, e3;
    mword_t f4, f3;
    logic op4, op3;
    drive(iv, s, fl, ordy);
    acc4 = iv && (q4.size() < 2);
    acc3 = iv && (q3.size() < 2);
    tk4  = (q4.size() > 0) && ordy;
    tk3  = (q3.size() > 0) && ordy;
    e4   = acc4 && !fl && (int'(s) >= 4);
    e3   = acc3 && !fl && (int'(s) >= 3);
    @(posedge clk);
    if (fl) begin
      q4.delete();
      q3.delete();
    end else begin
      if (tk4) void'(q4.pop_front());
      if (tk3) void'(q3.pop_front());
      if (acc4) q4.push_back(pick(din, s, 4));
      if (acc3) q3.push_back(pick(din, s, 3));
    end
    #1;
    f4 = (q4.size() > 0) ? q4[0] : '0;
    f3 = (q3.size() > 0) ? q3[0] : '0;
    op4 = 1'b0;
    op3 = 1'b0;
`ifdef SEL_PIPE_MUX_PARITY_EN
    op4 = if4.out_par;
    op3 = if3.out_par;
`endif
    cmp_model("m4", if4.out_valid, if4.in_ready, if4.sel_err, if4.out_data, if4.out_sel, op4,
              q4.size(), f4, e4);
    cmp_model("m3", if3.out_valid, if3.in_ready, if3.sel_err, if3.out_data, if3.out_sel, op3,
              q3.size(), f3, e3);
  endtask

  initial begin
    // iv sel fl ordy | ov od ir os err  (expected for the NUM_IN=4 instance)
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b1, 2'd1, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 32'hDDDDDDDD, 1'b1, 2'd3, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b1, 2'd1, 1'b0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'hDDDDDDDD, 1'b1, 2'd3, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0};

    din = {32'hDDDDDDDD, 32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA};
    drive(1'b0, 2'd0, 1'b0, 1'b0);

    // Reset state, then release and idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(if4.out_valid), 64'(1'b0));
    check("rst_in_ready", 64'(if4.in_ready), 64'(1'b1));
    check("rst_data", 64'(if4.out_data), 64'(32'h0));
    check("rst_sel_err", 64'(if4.sel_err), 64'(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b0);
      check("idle_data", 64'(if4.out_data), 64'(32'h0));
    end

    // Streaming, back-pressure and flush vectors.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].sel, tbl[i].fl, tbl[i].ordy);
      check($sformatf("tbl%0d_valid", i), 64'(if4.out_valid), 64'(tbl[i].ov));
      check($sformatf("tbl%0d_in_ready", i), 64'(if4.in_ready), 64'(tbl[i].ir));
      check($sformatf("tbl%0d_sel_err", i), 64'(if4.sel_err), 64'(tbl[i].err));
      if (tbl[i].ov) begin
        check($sformatf("tbl%0d_data", i), 64'(if4.out_data), 64'(tbl[i].od));
        check($sformatf("tbl%0d_sel", i), 64'(if4.out_sel), 64'(tbl[i].os));
      end
    end

    // Out-of-range select on the three-input instance.
    step(1'b1, 2'd3, 1'b0, 1'b1);
    check("oor_valid", 64'(if3.out_valid), 64'(1'b1));
    check("oor_data", 64'(if3.out_data), 64'(32'h0));
    check("oor_sel", 64'(if3.out_sel), 64'(2'd3));
    check("oor_err", 64'(if3.sel_err), 64'(1'b1));
    step(1'b1, 2'd2, 1'b0, 1'b1);
    check("oor_next_data", 64'(if3.out_data), 64'(32'hFFFFFFFF));
    check("oor_next_err", 64'(if3.sel_err), 64'(1'b0));
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("oor_idle_err", 64'(if3.sel_err), 64'(1'b0));
    step(1'b1, 2'd3, 1'b1, 1'b1);
    check("oor_flush_err", 64'(if3.sel_err), 64'(1'b0));
    check("oor_flush_valid", 64'(if3.out_valid), 64'(1'b0));
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("oor_flush_err2", 64'(if3.sel_err), 64'(1'b0));

`ifdef SEL_PIPE_MUX_PARITY_EN
    din = {32'h0, 32'h0, 32'h00000001, 32'hA5A5A5A5};
    step(1'b1, 2'd0, 1'b0, 1'b1);
    check("par_a5", 64'(if4.out_par), 64'(1'b0));
    step(1'b1, 2'd1, 1'b0, 1'b1);
    check("par_one_data", 64'(if4.out_data), 64'(32'h00000001));
    check("par_one", 64'(if4.out_par), 64'(1'b1));
    step(1'b0, 2'd0, 1'b0, 1'b1);
`endif

    // Randomised traffic with phases of heavy and light back-pressure.
    for (int i = 0; i < 400; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      step(1'(($urandom_range(0, 3)) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 15) == 0),
           1'(($urandom_range(0, 3)) < ((i / 50) % 2 == 0 ? 3 : 1)));
    end

    // Asynchronous reset mid-cycle with the pipe holding data.
    din = {32'hDDDDDDDD, 32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA};
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    q4.delete();
    q3.delete();
    check("arst_valid", 64'(if4.out_valid), 64'(1'b0));
    check("arst_in_ready", 64'(if4.in_ready), 64'(1'b1));
    check("arst_data", 64'(if4.out_data), 64'(32'h0));
    check("arst_sel", 64'(if4.out_sel), 64'(2'd0));
    check("arst_valid3", 64'(if3.out_valid), 64'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      check("arst_idle_data", 64'(if4.out_data), 64'(32'h0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
